fft_pe_driver: RTL and testbench

Initiator side of the 16-point radix-2 DIF butterfly PE interface. The block collects 16 real input samples into a complex buffer and runs 4 stages × 8 butterflies through the external PE. It issues each butterfly pair with its twiddle power, writes each returned result pair back in place, then streams the 16 spectrum words out. It sits between the sample source and the result sink, and owns the only connection to the PE.

---
 rtl/fft_pe_driver.sv | 213 +++++++++++++++++++++
 tb/tb_fft_pe_driver.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_pe_driver.sv
// fft_pe_driver: 16-point radix-2 DIF initiator that sequences butterflies through an external PE.
// Optional FFT_DRV_BITREV_EN: stream the spectrum in natural frequency order.
module fft_pe_driver (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [31:0] pe_a,
  output logic [31:0] pe_b,
  output logic [2:0]  pe_power,
  output logic        pe_ab_valid,
  input  logic [31:0] pe_fft_a,
  input  logic [31:0] pe_fft_b,
  input  logic        pe_valid,
  output logic [31:0] dout,
  output logic [3:0]  dout_idx,
  output logic        dout_valid,
  output logic        done
);
  typedef enum logic [1:0] {StLoad, StIssue, StDrain, StOut} state_e;

  state_e      state_q, state_d;
  logic [3:0]  n_q, n_d, m_q, m_d, wb_cnt_q, wb_cnt_d, iss_cnt_q, iss_cnt_d;
  logic [2:0]  k_q, k_d;
  logic [1:0]  s_q, s_d;
  logic [31:0] mem_q [16];
  logic [31:0] mem_d [16];
  logic [7:0]  tag_q [8];
  logic [7:0]  tag_d [8];

  logic        din_ready_d, pe_ab_valid_d, dout_valid_d, done_d;
  logic [31:0] pe_a_d, pe_b_d, dout_d;
  logic [2:0]  pe_power_d;
  logic [3:0]  dout_idx_d;

  logic        accept, wb_en, issue_go, out_go;
  logic [2:0]  issue_k;
  logic [1:0]  issue_s;
  logic [3:0]  issue_i, issue_j, wb_i, wb_j, out_m, rd_idx;

  function automatic logic [3:0] pair_lo(input logic [2:0] k, input logic [1:0] s);
    logic [3:0] kk, span;
    kk   = {1'b0, k};
    span = 4'd8 >> s;
    return ((kk >> (3'd3 - {1'b0, s})) << (3'd4 - {1'b0, s})) | (kk & (span - 4'd1));
  endfunction

  function automatic logic [2:0] twiddle(input logic [2:0] k, input logic [1:0] s);
    logic [3:0] span, t;
    span = 4'd8 >> s;
    t    = ({1'b0, k} & (span - 4'd1)) << s;
    return t[2:0];
  endfunction

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    m_d           = m_q;
    k_d           = k_q;
    s_d           = s_q;
    wb_cnt_d      = wb_cnt_q;
    iss_cnt_d     = iss_cnt_q;
    mem_d         = mem_q;
    tag_d         = tag_q;
    din_ready_d   = 1'b0;
    pe_a_d        = pe_a;
    pe_b_d        = pe_b;
    pe_power_d    = pe_power;
    pe_ab_valid_d = 1'b0;
    dout_d        = dout;
    dout_idx_d    = dout_idx;
    dout_valid_d  = 1'b0;
    done_d        = 1'b0;
    issue_go      = 1'b0;
    issue_k       = 3'd0;
    issue_s       = s_q;
    out_go        = 1'b0;
    out_m         = 4'd0;

    accept = (state_q == StLoad) && din_valid && din_ready;
    wb_i   = tag_q[wb_cnt_q[2:0]][7:4];
    wb_j   = tag_q[wb_cnt_q[2:0]][3:0];
    // Only results for butterflies already issued this stage are accepted.
    wb_en  = ((state_q == StIssue) || (state_q == StDrain)) && pe_valid && (wb_cnt_q < iss_cnt_q);

    if (wb_en) begin
      mem_d[wb_i] = pe_fft_a;
      mem_d[wb_j] = pe_fft_b;
      wb_cnt_d    = wb_cnt_q + 4'd1;
    end

    unique case (state_q)
      StLoad: begin
        din_ready_d = 1'b1;
        if (accept) begin
          mem_d[n_q] = {din, 16'h0000};
          n_d        = n_q + 4'd1;
          if (n_q == 4'd15) begin
            state_d     = StIssue;
            din_ready_d = 1'b0;
            s_d         = 2'd0;
            issue_go    = 1'b1;
            issue_s     = 2'd0;
          end
        end
      end
      StIssue: begin
        if (k_q == 3'd7) begin
          state_d = StDrain;
        end else begin
          issue_go = 1'b1;
          issue_k  = k_q + 3'd1;
        end
      end
      StDrain: begin
        if (wb_en && (wb_cnt_q == 4'd7)) begin
          if (s_q == 2'd3) begin
            state_d = StOut;
            out_go  = 1'b1;
          end else begin
            state_d  = StIssue;
            s_d      = s_q + 2'd1;
            issue_go = 1'b1;
            issue_s  = s_q + 2'd1;
          end
        end
      end
      StOut: begin
        if (m_q == 4'd15) begin
          state_d     = StLoad;
          din_ready_d = 1'b1;
        end else begin
          out_go = 1'b1;
          out_m  = m_q + 4'd1;
        end
      end
    endcase

    issue_i = pair_lo(issue_k, issue_s);
    issue_j = issue_i + (4'd8 >> issue_s);
    // Operands come from mem_d so a writeback landing on the same edge is forwarded.
    if (issue_go) begin
      k_d                   = issue_k;
      tag_d[issue_k]        = {issue_i, issue_j};
      pe_a_d                = mem_d[issue_i];
      pe_b_d                = mem_d[issue_j];
      pe_power_d            = twiddle(issue_k, issue_s);
      pe_ab_valid_d         = 1'b1;
      if (issue_k == 3'd0) begin
        wb_cnt_d  = 4'd0;
        iss_cnt_d = 4'd1;
      end else begin
        iss_cnt_d = iss_cnt_q + 4'd1;
      end
    end

`ifdef FFT_DRV_BITREV_EN
    rd_idx = {out_m[0], out_m[1], out_m[2], out_m[3]};
`else
    rd_idx = out_m;
`endif
    if (out_go) begin
      m_d          = out_m;
      dout_d       = mem_d[rd_idx];
      dout_idx_d   = out_m;
      dout_valid_d = 1'b1;
      done_d       = (out_m == 4'd15);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLoad;
      n_q         <= 4'd0;
      m_q         <= 4'd0;
      k_q         <= 3'd0;
      s_q         <= 2'd0;
      wb_cnt_q    <= 4'd0;
      iss_cnt_q   <= 4'd0;
      for (int i = 0; i < 16; i++) mem_q[i] <= 32'd0;
      for (int i = 0; i < 8; i++) tag_q[i] <= 8'd0;
      din_ready   <= 1'b0;
      pe_a        <= 32'd0;
      pe_b        <= 32'd0;
      pe_power    <= 3'd0;
      pe_ab_valid <= 1'b0;
      dout        <= 32'd0;
      dout_idx    <= 4'd0;
      dout_valid  <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      m_q         <= m_d;
      k_q         <= k_d;
      s_q         <= s_d;
      wb_cnt_q    <= wb_cnt_d;
      iss_cnt_q   <= iss_cnt_d;
      mem_q       <= mem_d;
      tag_q       <= tag_d;
      din_ready   <= din_ready_d;
      pe_a        <= pe_a_d;
      pe_b        <= pe_b_d;
      pe_power    <= pe_power_d;
      pe_ab_valid <= pe_ab_valid_d;
      dout        <= dout_d;
      dout_idx    <= dout_idx_d;
      dout_valid  <= dout_valid_d;
      done        <= done_d;
    end
  end
endmodule

// File: tb/tb_fft_pe_driver.sv
// Bench for fft_pe_driver: behavioural PE with programmable latency, issue and output scoreboards.
module tb_fft_pe_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = 16'd0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] pe_a, pe_b;
  logic [2:0]  pe_power;
  logic        pe_ab_valid;
  logic [31:0] pe_fft_a = 32'd0;
  logic [31:0] pe_fft_b = 32'd0;
  logic        pe_valid = 1'b0;
  logic [31:0] dout;
  logic [3:0]  dout_idx;
  logic        dout_valid;
  logic        done;

  fft_pe_driver dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .pe_a(pe_a), .pe_b(pe_b), .pe_power(pe_power), .pe_ab_valid(pe_ab_valid),
    .pe_fft_a(pe_fft_a), .pe_fft_b(pe_fft_b), .pe_valid(pe_valid),
    .dout(dout), .dout_idx(dout_idx), .dout_valid(dout_valid), .done(done)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  typedef struct {int i; int j; logic [2:0] p;} iss_t;
  typedef struct {int i; int j; logic [31:0] a; logic [31:0] b; int due;} pend_t;
  typedef struct {int pat; int lat; bit gaps; bit spur; bit use_model;
                  logic [31:0] e0; logic [31:0] er;} row_t;
  typedef struct {int k; logic [31:0] a; logic [31:0] b; logic [2:0] p;} ix_t;

  localparam int CosT [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  localparam int SinT [8] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  iss_t        iss_q[$];
  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] mb [16];
  logic [31:0] log_a [32];
  logic [31:0] log_b [32];
  logic [2:0]  log_p [32];
  int  pe_lat = 1;
  int  frame_issues = 0, frame_returns = 0, words_seen = 0, out_m = 0, first_dout_cyc = -1;
  bit  spur_req = 1'b0;
  logic [106:0] all_outs;

  assign all_outs = {din_ready, pe_a, pe_b, pe_power, pe_ab_valid, dout, dout_idx, dout_valid, done};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input logic [127:0] act,
                       input logic [127:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic void bfly(input logic [31:0] a, input logic [31:0] b, input logic [2:0] p,
                               output logic [31:0] fa, output logic [31:0] fb);
    int ar, ai, br, bi, dr, di, yr, yi;
    ar = int'($signed(a[31:16]));
    ai = int'($signed(a[15:0]));
    br = int'($signed(b[31:16]));
    bi = int'($signed(b[15:0]));
    dr = ar - br;
    di = ai - bi;
    yr = (dr * CosT[p] + di * SinT[p]) >>> 14;
    yi = (di * CosT[p] - dr * SinT[p]) >>> 14;
    fa = {16'(ar + br), 16'(ai + bi)};
    fb = {16'(yr), 16'(yi)};
  endfunction

  function automatic int bitrev(input int m);
    return ((m & 1) << 3) | ((m & 2) << 1) | ((m & 4) >> 1) | ((m & 8) >> 3);
  endfunction

  // PE model plus issue and output monitors, all sampled on the falling edge.
  always @(negedge clk) begin
    iss_t        e;
    pend_t       pr;
    logic [31:0] fa, fb;
    int          l;
    if (pe_ab_valid) begin
      if (iss_q.size() == 0) begin
        check("issue_extra", 1'b0, {pe_a, pe_b}, 0);
      end else begin
        e = iss_q.pop_front();
        check("issue_data", {pe_a, pe_b, pe_power} == {mb[e.i], mb[e.j], e.p},
              {pe_a, pe_b, pe_power}, {mb[e.i], mb[e.j], e.p});
        if (frame_issues % 8 == 0 && frame_issues > 0)
          check("stage_barrier", frame_returns >= frame_issues, frame_returns, frame_issues);
        if (frame_issues < 32) begin
          log_a[frame_issues] = pe_a;
          log_b[frame_issues] = pe_b;
          log_p[frame_issues] = pe_power;
        end
        bfly(pe_a, pe_b, pe_power, fa, fb);
        l = (pe_lat == 0) ? int'($urandom_range(6, 1)) : pe_lat;
        pend.push_back('{e.i, e.j, fa, fb, cyc + l});
      end
      frame_issues++;
    end
    pe_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      pr       = pend.pop_front();
      pe_valid = 1'b1;
      pe_fft_a = pr.a;
      pe_fft_b = pr.b;
      mb[pr.i] = pr.a;
      mb[pr.j] = pr.b;
      frame_returns++;
    end else if (spur_req) begin
      pe_valid = 1'b1;
      pe_fft_a = 32'hDEADBEEF;
      pe_fft_b = 32'h12345678;
      spur_req = 1'b0;
    end
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        check("dout_extra", 1'b0, dout, 0);
      end else begin
        fa = exp_q.pop_front();
        check("dout", dout == fa, dout, fa);
      end
      if (out_m == 0) first_dout_cyc = cyc;
      check("dout_idx", dout_idx == 4'(out_m), dout_idx, out_m);
      check("done", done == (out_m == 15), done, out_m == 15);
      out_m++;
      words_seen++;
    end
  end

  task automatic run_frame(input row_t r, input bit abort);
    logic [15:0] smp [16];
    logic [31:0] sw [16];
    logic [31:0] fa, fb;
    ix_t ix [3];
    int c_acc, span, i, t;
    bit spur_out;
    ix[0] = '{3, 32'h00030000, 32'h000B0000, 3'd3};
    ix[1] = '{0, 32'h00000000, 32'h00080000, 3'd0};
    ix[2] = '{7, 32'h00070000, 32'h000F0000, 3'd7};
    for (int n = 0; n < 16; n++) begin
      case (r.pat)
        0:       smp[n] = 16'(n);
        1:       smp[n] = 16'h0010;
        default: smp[n] = (n == 0) ? 16'h0100 : 16'h0000;
      endcase
      sw[n] = {smp[n], 16'h0000};
      mb[n] = sw[n];
    end
    iss_q.delete();
    exp_q.delete();
    for (int s = 0; s < 4; s++) begin
      span = 8 >> s;
      for (int g = 0; g < (1 << s); g++) begin
        for (int u = 0; u < span; u++) begin
          i = g * 2 * span + u;
          iss_q.push_back('{i, i + span, 3'(u << s)});
          bfly(sw[i], sw[i + span], 3'(u << s), fa, fb);
          sw[i]        = fa;
          sw[i + span] = fb;
        end
      end
    end
    for (int m = 0; m < 16; m++) begin
`ifdef FFT_DRV_BITREV_EN
      if (r.use_model) exp_q.push_back(sw[bitrev(m)]);
`else
      if (r.use_model) exp_q.push_back(sw[m]);
`endif
      else exp_q.push_back((m == 0) ? r.e0 : r.er);
    end
    pe_lat = r.lat;
    frame_issues = 0;
    frame_returns = 0;
    words_seen = 0;
    out_m = 0;
    first_dout_cyc = -1;
    if (r.spur) begin
      spur_req = 1'b1;
      tick();
      tick();
    end
    for (int n = 0; n < 16; n++) begin
      if (r.gaps && (n % 2 == 1)) begin
        din_valid = 1'b0;
        tick();
      end
      din = smp[n];
      din_valid = 1'b1;
      t = 0;
      while (!din_ready && t < 100) begin
        tick();
        t++;
      end
      if (t >= 100) check("load_ready", din_ready, din_ready, 1);
      tick();
    end
    c_acc = cyc;
    din_valid = 1'b0;
    if (abort) begin
      t = 0;
      while (frame_issues < 19 && t < 2000) begin
        tick();
        t++;
      end
      check("reach_stage2", frame_issues >= 19, frame_issues, 19);
      rst = 1'b1;
      #1;
      check("reset_mid_outputs", all_outs == '0, all_outs, 0);
      iss_q.delete();
      exp_q.delete();
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("ready_low_after_mid_rst", din_ready == 1'b0, din_ready, 0);
      repeat (12) tick();
      check("ready_after_mid_rst", din_ready == 1'b1, din_ready, 1);
      check("no_output_after_rst", words_seen == 0, words_seen, 0);
      return;
    end
    spur_out = r.spur;
    t = 0;
    while (words_seen < 16 && t < 4000) begin
      if (spur_out && words_seen >= 2) begin
        spur_req = 1'b1;
        spur_out = 1'b0;
      end
      tick();
      t++;
    end
    check("frame_words", words_seen == 16, words_seen, 16);
    if (r.lat == 1) check("latency", first_dout_cyc - c_acc == 36, first_dout_cyc - c_acc, 36);
    if (r.pat == 0) begin
      for (int q = 0; q < 3; q++)
        check("issue_table", {log_a[ix[q].k], log_b[ix[q].k], log_p[ix[q].k]} ==
              {ix[q].a, ix[q].b, ix[q].p}, {log_a[ix[q].k], log_b[ix[q].k], log_p[ix[q].k]},
              {ix[q].a, ix[q].b, ix[q].p});
    end
    tick();
    check("ready_after_done", din_ready == 1'b1, din_ready, 1);
  endtask

  initial begin
    row_t rows [8];
    row_t hand;
    rows[0] = '{0, 1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    rows[1] = '{1, 1, 1'b1, 1'b1, 1'b0, 32'h01000000, 32'h00000000};
    rows[2] = '{2, 3, 1'b0, 1'b0, 1'b0, 32'h01000000, 32'h01000000};
    rows[3] = '{0, 3, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    rows[4] = '{0, 7, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    rows[5] = '{0, 0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0};
    rows[6] = '{2, 0, 1'b0, 1'b1, 1'b0, 32'h01000000, 32'h01000000};
    rows[7] = '{2, 1, 1'b1, 1'b0, 1'b0, 32'h01000000, 32'h01000000};

    tick();
    tick();
    check("reset_state", all_outs == '0, all_outs, 0);
    rst = 1'b0;
    #1;
    check("ready_low_after_rst", din_ready == 1'b0, din_ready, 0);
    tick();
    check("ready_rise", din_ready == 1'b1, din_ready, 1);

    for (int r = 0; r < 8; r++) run_frame(rows[r], 1'b0);

    // Abort a ramp frame inside stage 2 with three results outstanding, then run a DC frame.
    hand = '{0, 7, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    run_frame(hand, 1'b1);
    hand = '{1, 1, 1'b0, 1'b0, 1'b0, 32'h01000000, 32'h00000000};
    run_frame(hand, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
